// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: phase encodings, opcode patterns, control-field codes and opcode classifier
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EX0 = 2'd1, S_EX1 = 2'd2, S_WAIT = 2'd3} state_t;
  typedef enum logic [3:0] {
    OP_ALU, OP_LDI, OP_STI, OP_BR, OP_PUSH, OP_BSET, OP_BCLR, OP_JMPR, OP_CALL, OP_LRLI
  } op_t;
  localparam logic [4:0] OPC_LDI  = 5'b10100;
  localparam logic [4:0] OPC_STI  = 5'b10101;
  localparam logic [3:0] OPC_BR   = 4'b1011;
  localparam logic [6:0] OPC_PUSH = 7'b1000000;
  localparam logic [6:0] OPC_BSET = 7'b1001001;
  localparam logic [6:0] OPC_BCLR = 7'b1001000;
  localparam logic [6:0] OPC_JMPR = 7'b1001101;
  localparam logic [6:0] OPC_CALL = 7'b1001110;
  localparam logic [6:0] OPC_LRLI = 7'b1000010;
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b11;
  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_K   = 2'b01;
  localparam logic [1:0] MD_MEM = 2'b10;
  localparam logic [1:0] SS_NONE = 2'b00;
  localparam logic [1:0] SS_PUSH = 2'b10;
  localparam logic [1:0] SS_POP  = 2'b01;
  localparam logic [4:0] FS_ADD = 5'b00010;
  localparam logic [4:0] FS_AND = 5'b01000;
  localparam logic [4:0] FS_OR  = 5'b01001;
  function automatic op_t decode_op(input logic [6:0] opc);
    return opc[6:2] == OPC_LDI  ? OP_LDI  :
           opc[6:2] == OPC_STI  ? OP_STI  :
           opc[6:3] == OPC_BR   ? OP_BR   :
           opc      == OPC_PUSH ? OP_PUSH :
           opc      == OPC_BSET ? OP_BSET :
           opc      == OPC_BCLR ? OP_BCLR :
           opc      == OPC_JMPR ? OP_JMPR :
           opc      == OPC_CALL ? OP_CALL :
           opc      == OPC_LRLI ? OP_LRLI : OP_ALU;
  endfunction
endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational control word and next phase from IR, phase, flags and literal bus
module cpu_ctrl_decode import cpu_ctrl_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic [15:0]       ir,
  input  state_t            state,
  input  logic              n_flag,
  input  logic              z_flag,
  input  logic [15:0]       instr_in,
  input  logic              instr_valid,
  input  logic              mem_ready,
  output state_t            state_d,
  output logic              flag_en,
  output logic [1:0]        ps,
  output logic              ir_load,
  output logic [RA_W-1:0]   aa,
  output logic [RA_W-1:0]   ba,
  output logic [RA_W-1:0]   da,
  output logic              wr,
  output logic [4:0]        fs,
  output logic [1:0]        mux_d,
  output logic              mux_a,
  output logic [DATA_W-1:0] k,
  output logic              mem_write,
  output logic [1:0]        ss
);
  op_t op;
  logic ex, mem_op, taken;
  logic [DATA_W-1:0] bit_mask;
  assign op       = decode_op(ir[15:9]);
  assign ex       = state != S_FETCH;
  assign mem_op   = op inside {OP_STI, OP_PUSH, OP_CALL};
  assign taken    = ir[11] ? n_flag : z_flag;
  assign bit_mask = DATA_W'(1) << ir[5:2];
  always_comb begin
    ps        = PS_HOLD;
    ir_load   = 1'b0;
    aa        = ex ? RA_W'(ir[5:3]) : '0;
    ba        = ex ? RA_W'(ir[2:0]) : '0;
    da        = ex ? RA_W'(ir[8:6]) : '0;
    wr        = 1'b0;
    fs        = ex ? ir[13:9] : '0;
    mux_d     = MD_ALU;
    mux_a     = 1'b0;
    k         = '0;
    mem_write = 1'b0;
    ss        = SS_NONE;
    state_d   = state;
    flag_en   = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = instr_valid ? S_EX0 : S_FETCH;
      end
      S_EX0, S_WAIT: begin
        if (mem_op) begin
          // the stalled access keeps its full control word until memory accepts it
          mem_write = 1'b1;
          ss        = op == OP_STI ? SS_NONE : SS_PUSH;
          mux_a     = op == OP_CALL;
          aa        = op == OP_STI ? RA_W'(ir[10:8]) : aa;
          k         = op == OP_STI ? DATA_W'(ir[7:0]) : '0;
          ps        = mem_ready && op != OP_CALL ? PS_INC : PS_HOLD;
          state_d   = !mem_ready ? S_WAIT : op == OP_CALL ? S_EX1 : S_FETCH;
        end else if (state == S_WAIT) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_FETCH;
          case (op)
            OP_LDI: begin
              wr    = 1'b1;
              da    = RA_W'(ir[10:8]);
              k     = DATA_W'(ir[7:0]);
              mux_d = MD_K;
              ps    = PS_INC;
            end
            OP_BR: begin
              ps    = taken ? PS_LOAD : PS_INC;
              k     = taken ? DATA_W'(ir[7:0]) : '0;
              mux_a = taken;
            end
            OP_BSET, OP_BCLR: begin
              wr      = 1'b1;
              aa      = RA_W'(ir[8:6]);
              fs      = op == OP_BSET ? FS_OR : FS_AND;
              k       = op == OP_BSET ? bit_mask : ~bit_mask;
              ps      = PS_INC;
              flag_en = 1'b1;
            end
            OP_JMPR: begin
              ps    = PS_LOAD;
              k     = DATA_W'(ir[8:0]);
              mux_a = 1'b1;
            end
            OP_LRLI: begin
              ps      = PS_INC;
              state_d = S_EX1;
            end
            default: begin
              wr      = 1'b1;
              ps      = PS_INC;
              flag_en = 1'b1;
            end
          endcase
        end
      end
      S_EX1: begin
        if (op == OP_CALL) begin
          ps      = PS_LOAD;
          k       = DATA_W'(ir[8:0]);
          state_d = S_FETCH;
        end else if (op == OP_LRLI) begin
          // the literal word is the only path from instr_in to the outputs
          k       = instr_valid ? DATA_W'(instr_in) : '0;
          wr      = instr_valid;
          mux_d   = instr_valid ? MD_K : MD_ALU;
          ps      = instr_valid ? PS_INC : PS_HOLD;
          state_d = instr_valid ? S_FETCH : S_EX1;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: instruction register, N/Z flags and phase register around the control decoder
module cpu_control_unit import cpu_ctrl_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_in,
  input  logic              instr_valid,
  input  logic              mem_ready,
  input  logic              n_in,
  input  logic              z_in,
  output logic [1:0]        ps,
  output logic              ir_load,
  output logic [RA_W-1:0]   aa,
  output logic [RA_W-1:0]   ba,
  output logic [RA_W-1:0]   da,
  output logic              wr,
  output logic [4:0]        fs,
  output logic [1:0]        mux_d,
  output logic              mux_a,
  output logic [DATA_W-1:0] k,
  output logic              mem_write,
  output logic [1:0]        ss,
  output logic [1:0]        state
);
  state_t state_q, state_d, state_cur;
  logic [15:0] ir_q, ir_d;
  logic n_q, n_d, z_q, z_d, flag_en;
  // during reset the decoder sees FETCH so no write or stack strobe escapes
  assign state_cur = rst ? S_FETCH : state_q;
  assign state     = state_cur;
  cpu_ctrl_decode #(.DATA_W(DATA_W), .RA_W(RA_W)) u_decode (
    .ir(ir_q), .state(state_cur), .n_flag(n_q), .z_flag(z_q),
    .instr_in(instr_in), .instr_valid(instr_valid), .mem_ready(mem_ready),
    .state_d(state_d), .flag_en(flag_en), .ps(ps), .ir_load(ir_load),
    .aa(aa), .ba(ba), .da(da), .wr(wr), .fs(fs), .mux_d(mux_d), .mux_a(mux_a),
    .k(k), .mem_write(mem_write), .ss(ss)
  );
  always_comb begin
    ir_d = ir_load && instr_valid ? instr_in : ir_q;
    n_d  = flag_en ? n_in : n_q;
    z_d  = flag_en ? z_in : z_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed and random instruction streams checked against a per-instruction cycle plan
module tb_cpu_control_unit;
  import cpu_ctrl_pkg::*;
  typedef struct packed {
    logic [1:0]  ps;
    logic        ir_load;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [2:0]  da;
    logic        wr;
    logic [4:0]  fs;
    logic [1:0]  mux_d;
    logic        mux_a;
    logic [31:0] k;
    logic        mem_write;
    logic [1:0]  ss;
    logic [1:0]  st;
  } cw_t;
  typedef struct {
    cw_t         cw;
    logic        valid;
    logic        ready;
    logic        n;
    logic        z;
    logic        upd;
    logic [15:0] din;
  } cyc_t;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, mem_ready = 1'b0, n_in = 1'b0, z_in = 1'b0;
  logic [15:0] instr_in = '0;
  logic [1:0] ps_a, mux_d_a, ss_a, state_a, ps_b, mux_d_b, ss_b, state_b;
  logic ir_load_a, wr_a, mux_a_a, mem_write_a, ir_load_b, wr_b, mux_a_b, mem_write_b;
  logic [2:0] aa_a, ba_a, da_a, aa_b, ba_b, da_b;
  logic [4:0] fs_a, fs_b;
  logic [15:0] k_a;
  logic [31:0] k_b;
  cw_t obs_a, obs_b;
  cyc_t q[$];
  int total = 0, bad = 0;
  logic n_m = 1'b0, z_m = 1'b0;
  always #5 clk = ~clk;
  cpu_control_unit #(.DATA_W(16), .RA_W(3)) dut_a (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .mem_ready(mem_ready),
    .n_in(n_in), .z_in(z_in), .ps(ps_a), .ir_load(ir_load_a), .aa(aa_a), .ba(ba_a), .da(da_a),
    .wr(wr_a), .fs(fs_a), .mux_d(mux_d_a), .mux_a(mux_a_a), .k(k_a), .mem_write(mem_write_a),
    .ss(ss_a), .state(state_a)
  );
  cpu_control_unit #(.DATA_W(32), .RA_W(3)) dut_b (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid), .mem_ready(mem_ready),
    .n_in(n_in), .z_in(z_in), .ps(ps_b), .ir_load(ir_load_b), .aa(aa_b), .ba(ba_b), .da(da_b),
    .wr(wr_b), .fs(fs_b), .mux_d(mux_d_b), .mux_a(mux_a_b), .k(k_b), .mem_write(mem_write_b),
    .ss(ss_b), .state(state_b)
  );
  assign obs_a = {ps_a, ir_load_a, aa_a, ba_a, da_a, wr_a, fs_a, mux_d_a, mux_a_a, 16'h0, k_a,
                  mem_write_a, ss_a, state_a};
  assign obs_b = {ps_b, ir_load_b, aa_b, ba_b, da_b, wr_b, fs_b, mux_d_b, mux_a_b, k_b,
                  mem_write_b, ss_b, state_b};
  function automatic cw_t idle_cw();
    cw_t c = '0;
    c.ir_load = 1'b1;
    return c;
  endfunction
  // expected cycle list for one instruction, written from the instruction's architectural effect
  function automatic void plan(input logic [15:0] ins, input int idle, input int stalls, input int litw,
                               input logic [15:0] lit, input logic n, input logic z);
    cyc_t c;
    cw_t b, e;
    logic [6:0] op = ins[15:9];
    logic taken;
    bit push_e = 1'b1;
    c.cw = idle_cw(); c.valid = 1'b0; c.ready = 1'($urandom); c.n = n; c.z = z; c.upd = 1'b0; c.din = '0;
    for (int i = 0; i < idle; i++) q.push_back(c);
    c.valid = 1'b1; c.din = ins;
    q.push_back(c);
    c.valid = 1'b0; c.din = '0;
    b = '0; b.aa = ins[5:3]; b.ba = ins[2:0]; b.da = ins[8:6]; b.fs = ins[13:9]; b.st = 2'd1;
    e = b;
    if (op[6:2] == 5'b10100) begin
      e.wr = 1'b1; e.da = ins[10:8]; e.k = 32'(ins[7:0]); e.mux_d = 2'b01; e.ps = 2'b01;
    end else if (op[6:2] == 5'b10101 || op == 7'b1000000 || op == 7'b1001110) begin
      e.mem_write = 1'b1;
      if (op[6:2] == 5'b10101) begin
        e.aa = ins[10:8]; e.k = 32'(ins[7:0]);
      end else e.ss = 2'b10;
      e.mux_a = op == 7'b1001110;
      for (int i = 0; i <= stalls; i++) begin
        c.cw = e;
        c.cw.st = i == 0 ? 2'd1 : 2'd3;
        c.ready = i == stalls;
        c.cw.ps = (i == stalls && op != 7'b1001110) ? 2'b01 : 2'b00;
        q.push_back(c);
      end
      push_e = 1'b0;
      if (op == 7'b1001110) begin
        e = b; e.st = 2'd2; e.ps = 2'b11; e.k = 32'(ins[8:0]);
        push_e = 1'b1;
      end
    end else if (op[6:3] == 4'b1011) begin
      taken = ins[11] ? n_m : z_m;
      e.ps = taken ? 2'b11 : 2'b01;
      if (taken) begin e.k = 32'(ins[7:0]); e.mux_a = 1'b1; end
    end else if (op == 7'b1001001 || op == 7'b1001000) begin
      e.k = 32'(1) << ins[5:2];
      if (op == 7'b1001000) e.k = ~e.k;
      e.wr = 1'b1; e.aa = ins[8:6]; e.fs = op == 7'b1001001 ? FS_OR : FS_AND; e.ps = 2'b01;
      c.upd = 1'b1;
    end else if (op == 7'b1001101) begin
      e.ps = 2'b11; e.k = 32'(ins[8:0]); e.mux_a = 1'b1;
    end else if (op == 7'b1000010) begin
      e.ps = 2'b01;
      c.cw = e; q.push_back(c);
      for (int j = 0; j < litw; j++) begin
        c.cw = b; c.cw.st = 2'd2; c.valid = 1'b0; c.din = 16'($urandom);
        q.push_back(c);
      end
      e = b; e.st = 2'd2; e.wr = 1'b1; e.mux_d = 2'b01; e.ps = 2'b01; e.k = 32'(lit);
      c.valid = 1'b1; c.din = lit;
    end else begin
      e.wr = 1'b1; e.ps = 2'b01; c.upd = 1'b1;
    end
    if (push_e) begin c.cw = e; q.push_back(c); end
  endfunction
  task automatic check(input string tag, input cw_t e);
    cw_t e16 = e;
    e16.k[31:16] = '0;
    total++;
    assert (obs_a === e16) else begin
      bad++;
      $error("FAIL %s w16 observed=%h expected=%h", tag, obs_a, e16);
    end
    total++;
    assert (obs_b === e) else begin
      bad++;
      $error("FAIL %s w32 observed=%h expected=%h", tag, obs_b, e);
    end
  endtask
  task automatic run(input string tag, input int n);
    int i = 0;
    while (q.size() > 0 && i < n) begin
      cyc_t c = q.pop_front();
      instr_valid = c.valid; instr_in = c.din; mem_ready = c.ready; n_in = c.n; z_in = c.z;
      @(negedge clk);
      check($sformatf("%s c%0d", tag, i), c.cw);
      @(posedge clk); #1;
      if (c.upd) begin n_m = c.n; z_m = c.z; end
      i++;
    end
    q.delete();
  endtask
  initial begin
    logic [31:0] r;
    logic [15:0] ins;
    @(negedge clk);
    check("reset", idle_cw());
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    plan(16'hA305, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("ldi", 99);
    plan(16'hAB42, 1, 3, 0, 16'h0, 1'b0, 1'b0); run("sti_stall", 99);
    plan(16'h0A53, 0, 0, 0, 16'h0, 1'b0, 1'b1); run("alu_z1", 99);
    plan(16'hB010, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("brz_taken", 99);
    plan(16'h0A53, 0, 0, 0, 16'h0, 1'b1, 1'b0); run("alu_z0", 99);
    plan(16'hB010, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("brz_not", 99);
    plan(16'hB8F3, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("brn_taken", 99);
    plan(16'h9C20, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("call", 99);
    plan(16'h9C20, 0, 2, 0, 16'h0, 1'b0, 1'b0); run("call_stall", 99);
    plan(16'h903C, 0, 0, 0, 16'h0, 1'b1, 1'b1); run("bclr15", 99);
    plan(16'h923C, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("bset15", 99);
    plan(16'h84C5, 0, 0, 2, 16'hBEEF, 1'b0, 1'b0); run("lrli", 99);
    plan(16'h9BFF, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("jmpr", 99);
    plan(16'h8018, 0, 1, 0, 16'h0, 1'b0, 1'b0); run("push", 99);
    plan(16'h0000, 0, 0, 0, 16'h0, 1'b1, 1'b1); run("alu_nz", 99);
    plan(16'hAC33, 0, 3, 0, 16'h0, 1'b1, 1'b1); run("sti_pre_rst", 2);
    rst = 1'b1; mem_ready = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    check("rst_in_wait", idle_cw());
    @(posedge clk); #1;
    rst = 1'b0; n_m = 1'b0; z_m = 1'b0;
    @(negedge clk);
    check("after_rst", idle_cw());
    @(posedge clk); #1;
    plan(16'hB020, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("brz_cleared", 99);
    plan(16'hB820, 0, 0, 0, 16'h0, 1'b0, 1'b0); run("brn_cleared", 99);
    for (int it = 0; it < 300; it++) begin
      r = $urandom;
      case ($urandom_range(0, 10))
        0: ins = {5'b10100, r[10:0]};
        1: ins = {5'b10101, r[10:0]};
        2: ins = {4'b1011, r[11:0]};
        3: ins = {7'b1000000, r[8:0]};
        4: ins = {7'b1001001, r[8:0]};
        5: ins = {7'b1001000, r[8:0]};
        6: ins = {7'b1001101, r[8:0]};
        7: ins = {7'b1001110, r[8:0]};
        8: ins = {7'b1000010, r[8:0]};
        default: ins = r[31:16];
      endcase
      plan(ins, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 16'($urandom),
           1'($urandom), 1'($urandom));
      run($sformatf("rnd%0d", it), 99);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
